ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  EX->MEM pipeline stage directly downstream of the 8-bit ALU. Latches ALU result plus
//  writeback/memory control into MEM, owns the architectural C and Z flag registers
//  (C feeds back as ALU cin), and exposes MEM-stage forwarding data. Supports stall/flush.
// PARAMETERS
//  DATA_W     8  datapath width (ALU operand/result width)
//  REG_IDX_W  3  register-file index width
// PORTS
//  clk             in   1          rising-edge clock
//  rst             in   1          synchronous, active-high reset
//  ex_valid        in   1          EX holds a real instruction
//  ex_alu_out      in   DATA_W     ALU result
//  ex_alu_cout     in   1          ALU carry/borrow/shift-out
//  ex_alu_z        in   1          ALU zero flag
//  ex_c_we/ex_z_we in   1 each     instruction updates C / Z
//  ex_rd           in   REG_IDX_W  destination register
//  ex_reg_we       in   1          writes register file
//  ex_mem_re/we    in   1 each     load / store
//  ex_store_data   in   DATA_W     store data
//  stall           in   1          hold this stage
//  flush           in   1          kill instruction in EX
//  cin             out  1          C flag register (to ALU cin)
//  flag_z          out  1          Z flag register
//  mem_valid       out  1          MEM holds a real instruction
//  mem_alu_result  out  DATA_W     latched ALU result (address/writeback)
//  mem_rd          out  REG_IDX_W  latched destination
//  mem_reg_we, mem_mem_re, mem_mem_we  out 1 each  latched controls, gated by mem_valid
//  mem_store_data  out  DATA_W     latched store data
//  fwd_en/fwd_rd/fwd_data  out 1/REG_IDX_W/DATA_W  MEM->EX forwarding source
// BEHAVIOUR
//  - Priority: rst > flush > stall > normal. accept = ex_valid & ~flush & ~stall.
//  - Reset: every output and flag 0 (cin=0, flag_z=0, mem_valid=0, all mem_*/fwd_* 0).
//  - accept: all mem_* <= ex_* next edge; mem_valid<=1. Latency 1 cycle.
//  - Flags on accept: c_we -> C<=ex_alu_cout; z_we -> Z<=ex_alu_z; else hold. cout of ops
//    not setting c_we (e.g. ADD_SIGNED, undefined cout) never reaches C.
//  - Flag written at edge N is seen via cin by the instruction in EX at cycle N+1; no bypass.
//  - flush (with or without stall): mem_valid<=0; mem_reg_we/mem_mem_re/mem_mem_we<=0;
//    flags unchanged; data regs hold.
//  - stall & ~flush: all MEM regs and flags hold exactly.
//  - ~ex_valid & ~stall & ~flush: bubble, same as flush.
//  - Invariant: mem_reg_we|mem_mem_re|mem_mem_we implies mem_valid.
//  - fwd_en = mem_valid & mem_reg_we & ~mem_mem_re (load data not ready in MEM);
//    fwd_rd = mem_rd; fwd_data = mem_alu_result. Combinational from registers.
//  - rst mid-stall/flush: reset wins that edge; pipeline restarts empty.
// STRUCTURE
//  - Package exec_pkg: DATA_W, REG_IDX_W, typedef flags_t {c,z}, typedef mem_ctrl_t
//    {reg_we, mem_re, mem_we}, shared by ID/EX, EX/MEM and hazard unit.
//  - Sub-module flag_reg: C/Z registers with per-flag write enables and global hold.
// TESTING
//  1 rst high 2 cycles with ex_valid=1 -> all outputs 0, cin=0, mem_valid=0.
//  2 ALU 0xFF+0x01: out=0x00,cout=1,z=1,c_we=z_we=1,rd=2,reg_we=1 -> next cycle cin=1,
//    flag_z=1, mem_alu_result=0x00, mem_rd=2, fwd_en=1.
//  3 then AND: out=0x5A,cout=0,c_we=0,z_we=1 -> cin stays 1, flag_z=0.
//  4 stall 3 cycles while ex_* changes -> mem_*, cin, flag_z frozen; release -> 1 cycle capture.
//  5 flush&stall with ex_valid=1,c_we=1,cout=0 -> mem_valid=0, all ctrls 0, cin unchanged.
//  6 load in MEM (mem_re=1,reg_we=1,rd=5) -> fwd_en=0; next ALU op rd=3 data 0x42 -> fwd_en=1,
//    fwd_rd=3, fwd_data=0x42; following bubble -> fwd_en=0.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared execute-side types and widths.
// Used by the ID/EX stage, the EX/MEM stage and the hazard unit.
// Contents:
//   DATA_W      datapath width (ALU operand/result width)
//   REG_IDX_W   register-file index width
//   flags_t     architectural condition flags {c, z}
//   mem_ctrl_t  writeback/memory controls carried down the pipe
package exec_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned REG_IDX_W = 3;

    typedef struct packed {
        logic c;
        logic z;
    } flags_t;

    typedef struct packed {
        logic reg_we;
        logic mem_re;
        logic mem_we;
    } mem_ctrl_t;

endpackage

// File: rtl/flag_reg.sv
// Architectural C/Z flag registers.
// Each flag has its own write enable. A global hold freezes both flags,
// whatever the write enables say.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset; clears both flags
//   hold   when high, both flags keep their value
//   c_we   load d.c into C (ignored while hold is high)
//   z_we   load d.z into Z (ignored while hold is high)
//   d      candidate flag values from the ALU
//   q      current flag values
module flag_reg
    import exec_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   hold,
    input  logic   c_we,
    input  logic   z_we,
    input  flags_t d,
    output flags_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (!hold) begin
            if (c_we) q.c <= d.c;
            if (z_we) q.z <= d.z;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register, sitting directly downstream of the 8-bit ALU.
// It latches the ALU result and the writeback/memory controls into MEM.
// It owns the C/Z flags; C feeds back to the ALU as cin.
// It also exposes the MEM-stage forwarding source.
// Priority: rst > flush > stall > normal.
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   ex_*                     instruction currently in EX (ALU result, flags, controls)
//   stall                    hold the MEM registers and the flags
//   flush                    kill the instruction in EX (a bubble enters MEM)
//   cin, flag_z              architectural C and Z flags
//   mem_valid, mem_*         latched MEM-stage instruction; controls are gated by mem_valid
//   fwd_en/fwd_rd/fwd_data   MEM->EX forwarding source
module ex_mem_stage
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W    = exec_pkg::DATA_W,
    parameter int unsigned REG_IDX_W = exec_pkg::REG_IDX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic [DATA_W-1:0]    ex_alu_out,
    input  logic                 ex_alu_cout,
    input  logic                 ex_alu_z,
    input  logic                 ex_c_we,
    input  logic                 ex_z_we,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_reg_we,
    input  logic                 ex_mem_re,
    input  logic                 ex_mem_we,
    input  logic [DATA_W-1:0]    ex_store_data,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 cin,
    output logic                 flag_z,
    output logic                 mem_valid,
    output logic [DATA_W-1:0]    mem_alu_result,
    output logic [REG_IDX_W-1:0] mem_rd,
    output logic                 mem_reg_we,
    output logic                 mem_mem_re,
    output logic                 mem_mem_we,
    output logic [DATA_W-1:0]    mem_store_data,
    output logic                 fwd_en,
    output logic [REG_IDX_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]    fwd_data
);

    logic                 accept;
    logic                 bubble;
    logic                 valid_q;
    mem_ctrl_t            ctrl_q;
    logic [DATA_W-1:0]    result_q;
    logic [REG_IDX_W-1:0] rd_q;
    logic [DATA_W-1:0]    store_q;
    flags_t               flags_d;
    flags_t               flags_q;

    assign accept = ex_valid & ~flush & ~stall;
    // A flush always empties MEM; an invalid EX slot empties it only when not stalled.
    assign bubble = flush | (~ex_valid & ~stall);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            result_q <= '0;
            rd_q     <= '0;
            store_q  <= '0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            ctrl_q   <= '{reg_we: ex_reg_we, mem_re: ex_mem_re, mem_we: ex_mem_we};
            result_q <= ex_alu_out;
            rd_q     <= ex_rd;
            store_q  <= ex_store_data;
        end else if (bubble) begin
            // Data registers keep their value; only the valid bit and the controls are killed.
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end
    end

    // Flags move only with an accepted instruction, so a killed or stalled
    // instruction never disturbs C/Z. No bypass: EX sees the new value one cycle later.
    assign flags_d = '{c: ex_alu_cout, z: ex_alu_z};

    flag_reg u_flag_reg (
        .clk  (clk),
        .rst  (rst),
        .hold (~accept),
        .c_we (ex_c_we),
        .z_we (ex_z_we),
        .d    (flags_d),
        .q    (flags_q)
    );

    assign cin    = flags_q.c;
    assign flag_z = flags_q.z;

    assign mem_valid      = valid_q;
    assign mem_alu_result = result_q;
    assign mem_rd         = rd_q;
    assign mem_reg_we     = valid_q & ctrl_q.reg_we;
    assign mem_mem_re     = valid_q & ctrl_q.mem_re;
    assign mem_mem_we     = valid_q & ctrl_q.mem_we;
    assign mem_store_data = store_q;

    // Load data does not exist yet in MEM, so a load is never a forwarding source.
    assign fwd_en   = valid_q & ctrl_q.reg_we & ~ctrl_q.mem_re;
    assign fwd_rd   = rd_q;
    assign fwd_data = result_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

    typedef struct {
        logic       rst;
        logic       stall;
        logic       flush;
        logic       v;
        logic [7:0] out;
        logic       cout;
        logic       z;
        logic       cwe;
        logic       zwe;
        logic [2:0] rd;
        logic       rwe;
        logic       re;
        logic       we;
        logic [7:0] sd;
    } in_t;

    typedef struct {
        logic       cin;
        logic       fz;
        logic       valid;
        logic [7:0] res;
        logic [2:0] rd;
        logic       rwe;
        logic       re;
        logic       we;
        logic [7:0] sd;
        logic       fwd;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, ex_valid, ex_alu_cout, ex_alu_z, ex_c_we, ex_z_we;
    logic [7:0] ex_alu_out, ex_store_data;
    logic [2:0] ex_rd;
    logic       ex_reg_we, ex_mem_re, ex_mem_we, stall, flush;
    logic       cin, flag_z, mem_valid, mem_reg_we, mem_mem_re, mem_mem_we, fwd_en;
    logic [7:0] mem_alu_result, mem_store_data, fwd_data;
    logic [2:0] mem_rd, fwd_rd;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_alu_out     (ex_alu_out),
        .ex_alu_cout    (ex_alu_cout),
        .ex_alu_z       (ex_alu_z),
        .ex_c_we        (ex_c_we),
        .ex_z_we        (ex_z_we),
        .ex_rd          (ex_rd),
        .ex_reg_we      (ex_reg_we),
        .ex_mem_re      (ex_mem_re),
        .ex_mem_we      (ex_mem_we),
        .ex_store_data  (ex_store_data),
        .stall          (stall),
        .flush          (flush),
        .cin            (cin),
        .flag_z         (flag_z),
        .mem_valid      (mem_valid),
        .mem_alu_result (mem_alu_result),
        .mem_rd         (mem_rd),
        .mem_reg_we     (mem_reg_we),
        .mem_mem_re     (mem_mem_re),
        .mem_mem_we     (mem_mem_we),
        .mem_store_data (mem_store_data),
        .fwd_en         (fwd_en),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data)
    );

    task automatic chk(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step %0d %s: got 0x%0h, expected 0x%0h", step, name, act, exp);
        end
    endtask

    task automatic compare(input int step, input exp_t e);
        chk("cin", step, 32'(cin), 32'(e.cin));
        chk("flag_z", step, 32'(flag_z), 32'(e.fz));
        chk("mem_valid", step, 32'(mem_valid), 32'(e.valid));
        chk("mem_alu_result", step, 32'(mem_alu_result), 32'(e.res));
        chk("mem_rd", step, 32'(mem_rd), 32'(e.rd));
        chk("mem_reg_we", step, 32'(mem_reg_we), 32'(e.rwe));
        chk("mem_mem_re", step, 32'(mem_mem_re), 32'(e.re));
        chk("mem_mem_we", step, 32'(mem_mem_we), 32'(e.we));
        chk("mem_store_data", step, 32'(mem_store_data), 32'(e.sd));
        chk("fwd_en", step, 32'(fwd_en), 32'(e.fwd));
        chk("fwd_rd", step, 32'(fwd_rd), 32'(e.rd));
        chk("fwd_data", step, 32'(fwd_data), 32'(e.res));
        chk("ctrl_implies_valid", step,
            32'((mem_reg_we | mem_mem_re | mem_mem_we) & ~mem_valid), 32'd0);
    endtask

    // Drive on the falling edge, queue the expectation, compare just after the rising edge.
    task automatic apply(input int step, input vec_t vv);
        @(negedge clk);
        rst           = vv.i.rst;
        stall         = vv.i.stall;
        flush         = vv.i.flush;
        ex_valid      = vv.i.v;
        ex_alu_out    = vv.i.out;
        ex_alu_cout   = vv.i.cout;
        ex_alu_z      = vv.i.z;
        ex_c_we       = vv.i.cwe;
        ex_z_we       = vv.i.zwe;
        ex_rd         = vv.i.rd;
        ex_reg_we     = vv.i.rwe;
        ex_mem_re     = vv.i.re;
        ex_mem_we     = vv.i.we;
        ex_store_data = vv.i.sd;
        sb_q.push_back(vv.e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL step %0d scoreboard: got empty queue, expected one entry", step);
        end else begin
            compare(step, sb_q.pop_front());
        end
    endtask

    vec_t tbl[17];
    vec_t hv;

    initial begin
        // Inputs:   rst stl fls v out cout z cwe zwe rd rwe re we sd
        // Expected: cin fz valid res rd rwe re we sd fwd
        // Reset held two cycles with a valid instruction present.
        tbl[0]  = '{'{1,0,0,1,8'hAA,1,1,1,1,3'd7,1,1,1,8'h33}, '{0,0,0,8'h00,3'd0,0,0,0,8'h00,0}};
        tbl[1]  = '{'{1,0,0,1,8'hAA,1,1,1,1,3'd7,1,1,1,8'h33}, '{0,0,0,8'h00,3'd0,0,0,0,8'h00,0}};
        // 0xFF+0x01: carry out and zero, both flags written.
        tbl[2]  = '{'{0,0,0,1,8'h00,1,1,1,1,3'd2,1,0,0,8'h11}, '{1,1,1,8'h00,3'd2,1,0,0,8'h11,1}};
        // AND: only Z written, so C stays 1.
        tbl[3]  = '{'{0,0,0,1,8'h5A,0,0,0,1,3'd1,1,0,0,8'h22}, '{1,0,1,8'h5A,3'd1,1,0,0,8'h22,1}};
        // Three stall cycles while EX keeps changing: everything frozen.
        tbl[4]  = '{'{0,1,0,1,8'h01,0,1,1,1,3'd4,0,0,1,8'h44}, '{1,0,1,8'h5A,3'd1,1,0,0,8'h22,1}};
        tbl[5]  = '{'{0,1,0,0,8'h02,0,1,1,1,3'd5,0,1,1,8'h45}, '{1,0,1,8'h5A,3'd1,1,0,0,8'h22,1}};
        tbl[6]  = '{'{0,1,0,1,8'h03,0,1,1,1,3'd6,1,0,1,8'h46}, '{1,0,1,8'h5A,3'd1,1,0,0,8'h22,1}};
        // Stall released: captured in one cycle (store, no reg write).
        tbl[7]  = '{'{0,0,0,1,8'h77,0,0,0,1,3'd4,0,0,1,8'h44}, '{1,0,1,8'h77,3'd4,0,0,1,8'h44,0}};
        // Flush with stall: bubble, C untouched despite c_we with cout=0, data held.
        tbl[8]  = '{'{0,1,1,1,8'h99,0,1,1,1,3'd6,1,1,0,8'h55}, '{1,0,0,8'h77,3'd4,0,0,0,8'h44,0}};
        // Load in MEM is not a forwarding source.
        tbl[9]  = '{'{0,0,0,1,8'h80,0,0,0,0,3'd5,1,1,0,8'h00}, '{1,0,1,8'h80,3'd5,1,1,0,8'h00,0}};
        // ALU op to r3 with 0x42 forwards.
        tbl[10] = '{'{0,0,0,1,8'h42,0,0,0,1,3'd3,1,0,0,8'h00}, '{1,0,1,8'h42,3'd3,1,0,0,8'h00,1}};
        // Bubble from invalid EX: forwarding drops, data held.
        tbl[11] = '{'{0,0,0,0,8'hEE,1,1,1,1,3'd7,1,0,0,8'hFF}, '{1,0,0,8'h42,3'd3,0,0,0,8'h00,0}};
        // c_we with cout=0 clears C; z_we=0 keeps Z at 0 though ALU z=1.
        tbl[12] = '{'{0,0,0,1,8'h10,0,1,1,0,3'd1,1,0,0,8'h01}, '{0,0,1,8'h10,3'd1,1,0,0,8'h01,1}};
        // Signed add style: cout=1 but c_we=0 never reaches C; Z written.
        tbl[13] = '{'{0,0,0,1,8'h00,1,1,0,1,3'd2,1,0,0,8'h02}, '{0,1,1,8'h00,3'd2,1,0,0,8'h02,1}};
        // Flush without stall: bubble, flags untouched.
        tbl[14] = '{'{0,0,1,1,8'hC3,1,0,1,1,3'd7,1,0,1,8'h09}, '{0,1,0,8'h00,3'd2,0,0,0,8'h02,0}};
        // Accept setting C only.
        tbl[15] = '{'{0,0,0,1,8'h3C,1,0,1,0,3'd6,1,0,0,8'h66}, '{1,1,1,8'h3C,3'd6,1,0,0,8'h66,1}};
        // Stall with an invalid EX slot: hold, not a bubble.
        tbl[16] = '{'{0,1,0,0,8'h00,0,0,1,1,3'd0,0,0,0,8'h00}, '{1,1,1,8'h3C,3'd6,1,0,0,8'h66,1}};

        for (int k = 0; k < 17; k++) apply(k, tbl[k]);

        // Reset asserted together with stall and flush wins that edge.
        hv = '{'{1,1,1,1,8'hAB,1,1,1,1,3'd5,1,1,1,8'hCD}, '{0,0,0,8'h00,3'd0,0,0,0,8'h00,0}};
        apply(100, hv);
        // Pipeline restarts empty and accepts immediately; C/Z still clear.
        hv = '{'{0,0,0,1,8'h05,1,0,0,0,3'd1,0,0,1,8'h77}, '{0,0,1,8'h05,3'd1,0,0,1,8'h77,0}};
        apply(101, hv);
        // Back-to-back accept right after a flush cycle.
        hv = '{'{0,0,1,1,8'h06,1,1,1,1,3'd2,1,0,0,8'h00}, '{0,0,0,8'h05,3'd1,0,0,0,8'h77,0}};
        apply(102, hv);
        hv = '{'{0,0,0,1,8'h00,1,1,1,1,3'd2,1,0,0,8'h88}, '{1,1,1,8'h00,3'd2,1,0,0,8'h88,1}};
        apply(103, hv);

        chk("scoreboard_drained", 999, 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
